keccak_squeeze_serializer: RTL and testbench
============================================

Name: keccak_squeeze_serializer

Overview:
- Consumer end of the Keccak permutation delay chain. Sits after the 24-cycle valid delay line.
- On the delayed valid pulse, captures the digest portion of the 1600-bit state.
- Streams the digest as WORD_WIDTH words over a valid/ready interface to the host/output FIFO.
- The delay chain cannot stall, so the block flags any pulse that arrives while it is still busy.

Parameters:
- STATE_WIDTH, 1600, permutation state width in bits.
- WORD_WIDTH, 64, output bus width; one Keccak lane.
- OUT_WORDS, 4, digest words per result; 4 gives SHA3-256. Legal range is 1 to STATE_WIDTH/WORD_WIDTH.

Ports:
- clk, input, 1, single clock, rising edge.
- resetn, input, 1, asynchronous active-low reset.
- enable, input, 1, global clock-enable; the same meaning as on the delay chain.
- in_valid, input, 1, one-cycle pulse from the delay-chain output: the state is final.
- in_state, input, STATE_WIDTH, permutation state; lane k is in_state[k*64 +: 64].
- out_ready, input, 1, downstream can accept a word.
- out_valid, output, 1, out_data holds a valid word.
- out_data, output, WORD_WIDTH, digest word.
- out_last, output, 1, marks the final word (index OUT_WORDS-1).
- busy, output, 1, a result is held or being sent.
- overrun, output, 1, sticky: a result was dropped.

Behaviour:
- Reset: asynchronous, active-low. Resets the FSM to IDLE, the word counter to 0, the capture register to 0 and overrun to 0. Outputs out_valid=0, out_data=0, out_last=0, busy=0.
- Reset mid-stream: the current result is abandoned immediately, with no further beats.
- FSM states: IDLE and SEND.
- IDLE -> SEND: when enable=1 and in_valid=1. On that edge the block:
  - captures in_state[OUT_WORDS*WORD_WIDTH-1:0] into the capture register;
  - sets the counter to 0.
- Latency: in_valid sampled at edge T, so out_valid=1 with word 0 after edge T.
- In SEND:
  - out_valid_q=1 (internal registered valid);
  - out_data = word[counter];
  - out_last = (counter == OUT_WORDS-1);
  - busy=1.
- Beat: counted when enable=1, out_valid=1 and out_ready=1. A beat advances the counter by 1.
- Beat with out_last=1: SEND -> IDLE and the counter clears.
- Back-to-back: if in_valid=1 on the same edge as the last beat, the new state is captured and the FSM stays in SEND with counter 0. No bubble, no overrun.
- Overrun: in_valid=1 in SEND with no last beat that edge. The pulse is dropped, overrun is set to 1 and held until reset, and the in-flight stream is not disturbed.
- enable=0: all registers hold.
  - out_valid is out_valid_q AND enable, so no beat can complete while disabled and no word is lost.
  - in_valid is ignored; the delay chain is frozen by the same enable.
- out_data holds a stable value while out_valid=1 and out_ready=0.
- out_data is 0 in IDLE.
- With OUT_WORDS=1, every word has out_last=1.

Optional Feature:
- Macro: KECCAK_OUT_BSWAP_EN.
- Defined: each output word is byte-reversed, giving a big-endian byte stream on the bus. out_data[7:0] = lane[63:56], and so on.
- Undefined: the lane is passed unchanged (Keccak little-endian byte order).
- Control timing and handshake are the same in both builds.

Decomposition:
- Shared package keccak_pkg holds:
  - KECCAK_STATE_WIDTH=1600, KECCAK_LANE_WIDTH=64, KECCAK_ROUNDS=24; the delay chain's N_CLOCKs takes KECCAK_ROUNDS;
  - squeeze FSM state encodings SQ_IDLE=1'b0 and SQ_SEND=1'b1.
- One sub-module, keccak_word_sel: a combinational mux from the capture register and counter to a word. It contains the KECCAK_OUT_BSWAP_EN byte-swap.
- The capture and counter registers are written in-module.

Test Plan:
1. Reset behaviour: assert resetn=0 mid-SEND at word 2 -> all outputs 0 immediately; after release, busy=0 and no further out_valid.
2. Basic stream (out_ready=1, enable=1, no swap): in_valid with lane0..3 = 0x0000000000000001, ...02, ...03, ...04 -> 4 consecutive words 1,2,3,4 starting the cycle after the pulse; out_last only on 4; busy drops after the 4th beat.
3. Backpressure: out_ready toggles 1,0,0,1,... -> each word is held stable while stalled, no word is skipped or repeated, and the total is exactly 4 beats.
4. Back-to-back and overrun:
   - second in_valid on the same edge as the last beat -> new digest starts with no gap and overrun=0;
   - third in_valid at word 1 -> overrun=1 (sticky) and the stream completes intact.
5. Enable gating: drop enable for 5 cycles at word 2 with out_ready=1 -> out_valid=0 throughout, then resume at word 2; in_valid pulses during the gap are ignored.
6. Byte swap build with KECCAK_OUT_BSWAP_EN: lane0 = 0x0123456789ABCDEF -> out_data = 0xEFCDAB8967452301; without the macro -> 0x0123456789ABCDEF.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak constants and squeeze FSM encodings.
// Imported by the squeeze serializer and its word selector.
package keccak_pkg;

   localparam int KECCAK_STATE_WIDTH = 1600;
   localparam int KECCAK_LANE_WIDTH  = 64;
   localparam int KECCAK_ROUNDS      = 24;

   typedef enum logic {
      SQ_IDLE = 1'b0,
      SQ_SEND = 1'b1
   } sq_state_e;

endpackage

// File: rtl/keccak_word_sel.sv
// Selects one digest word from the capture register.
// Build option: KECCAK_OUT_BSWAP_EN byte-reverses each word.
module keccak_word_sel
   import keccak_pkg::*;
#(
   parameter int WORD_WIDTH = KECCAK_LANE_WIDTH,
   parameter int OUT_WORDS  = 4,
   parameter int CW         = 2
) (
   input  logic [OUT_WORDS*WORD_WIDTH-1:0] cap_i,
   input  logic [CW-1:0]                   cnt_i,
   output logic [WORD_WIDTH-1:0]           word_o
);

   logic [WORD_WIDTH-1:0] lane;

   // pick lane[cnt] and optionally reverse its byte order
   always_comb begin
      lane = cap_i[cnt_i*WORD_WIDTH +: WORD_WIDTH];
`ifdef KECCAK_OUT_BSWAP_EN
      word_o = '0;
      for (int b = 0; b < WORD_WIDTH / 8; b++) begin
         word_o[b*8 +: 8] = lane[WORD_WIDTH-8-b*8 +: 8];
      end
`else
      word_o = lane;
`endif
   end

endmodule

// File: rtl/keccak_squeeze_serializer.sv
// Captures the digest on the delayed valid pulse and streams it
// as WORD_WIDTH words; optional KECCAK_OUT_BSWAP_EN byte swap.
module keccak_squeeze_serializer
   import keccak_pkg::*;
#(
   parameter int STATE_WIDTH = KECCAK_STATE_WIDTH,
   parameter int WORD_WIDTH  = KECCAK_LANE_WIDTH,
   parameter int OUT_WORDS   = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   enable,
   input  logic                   in_valid,
   input  logic [STATE_WIDTH-1:0] in_state,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [WORD_WIDTH-1:0]  out_data,
   output logic                   out_last,
   output logic                   busy,
   output logic                   overrun
);

   localparam int DW = OUT_WORDS * WORD_WIDTH;
   localparam int CW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(OUT_WORDS - 1);

   sq_state_e      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]  cap_q, cap_d;
   logic           overrun_q, overrun_d;

   logic                  send;
   logic                  is_last;
   logic                  beat;
   logic                  take;
   logic [WORD_WIDTH-1:0] word;

   // only the digest lanes are ever captured
   if (DW < STATE_WIDTH) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^in_state[STATE_WIDTH-1:DW];
   end

   keccak_word_sel #(
      .WORD_WIDTH (WORD_WIDTH),
      .OUT_WORDS  (OUT_WORDS),
      .CW         (CW)
   ) u_word_sel (
      .cap_i  (cap_q),
      .cnt_i  (cnt_q),
      .word_o (word)
   );

   assign send      = (state_q == SQ_SEND);
   assign is_last   = send && (cnt_q == LAST_IDX);
   assign out_valid = send & enable;
   assign beat      = out_valid & out_ready;
   assign take      = enable & in_valid;
   assign out_data  = send ? word : '0;
   assign out_last  = is_last;
   assign busy      = send;
   assign overrun   = overrun_q;

   // next state: capture, advance on beats, flag dropped pulses
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_d     = cap_q;
      overrun_d = overrun_q;
      unique case (state_q)
         SQ_IDLE: begin
            if (take) begin
               state_d = SQ_SEND;
               cap_d   = in_state[DW-1:0];
               cnt_d   = '0;
            end
         end
         SQ_SEND: begin
            if (beat && is_last) begin
               cnt_d = '0;
               if (take) begin
                  cap_d = in_state[DW-1:0];
               end else begin
                  state_d = SQ_IDLE;
               end
            end else begin
               if (beat) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (take) begin
                  overrun_d = 1'b1;
               end
            end
         end
      endcase
   end

   // state registers; reset abandons any stream in flight
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= SQ_IDLE;
         cnt_q     <= '0;
         cap_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cap_q     <= cap_d;
         overrun_q <= overrun_d;
      end
   end

endmodule

// File: tb/tb_keccak_squeeze_serializer.sv
// Self-checking bench for keccak_squeeze_serializer.
// Expected words come from a lane/byte model of the state.
module tb_keccak_squeeze_serializer;

   localparam int SW = 1600;
   localparam int WW = 64;
   localparam int OW = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          enable;
   logic          in_valid;
   logic [SW-1:0] in_state;
   logic          out_ready;
   logic          out_valid;
   logic [WW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          overrun;

   int checks = 0;
   int errors = 0;

   keccak_squeeze_serializer #(
      .STATE_WIDTH (SW),
      .WORD_WIDTH  (WW),
      .OUT_WORDS   (OW)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_state  (in_state),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [SW-1:0] rand_state();
      logic [SW-1:0] s;
      for (int i = 0; i < SW / 32; i++) s[i*32 +: 32] = $urandom;
      return s;
   endfunction

   // lane k of the state as it should appear on the bus
   function automatic logic [WW-1:0] exp_word(input logic [SW-1:0] s,
                                              input int k);
      logic [WW-1:0] w;
      logic [WW-1:0] r;
      w = s[k*WW +: WW];
`ifdef KECCAK_OUT_BSWAP_EN
      for (int b = 0; b < WW / 8; b++) r[b*8 +: 8] = w[(WW/8-1-b)*8 +: 8];
`else
      r = w;
`endif
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      enable    = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_state  = rand_state();
      #1;
      checks++;
      if ({out_valid, out_last, busy, overrun} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0000",
                  {out_valid, out_last, busy, overrun});
      end
      checks++;
      if (out_data !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h want 0", out_data);
      end
      tick();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [SW-1:0] s;
      s = rand_state();
      for (int k = 0; k < OW; k++) s[k*WW +: WW] = 64'(k + 1);
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: got v=%b b=%b want 0 0", out_valid, busy);
      end
      in_valid = 1'b1;
      in_state = s;
      tick();
      in_valid = 1'b0;
      in_state = rand_state();
      for (int k = 0; k < OW; k++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1 ||
             out_data !== exp_word(s, k) || out_last !== 1'(k == OW - 1)) begin
            errors++;
            $display("FAIL basic_word%0d: got v=%b b=%b d=%h l=%b want 1 1 %h %b",
                     k, out_valid, busy, out_data, out_last,
                     exp_word(s, k), 1'(k == OW - 1));
         end
         tick();
      end
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL basic_done: got v=%b b=%b d=%h want 0 0 0",
                  out_valid, busy, out_data);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [SW-1:0] s;
      int idx;
      int cyc;
      s = rand_state();
      idx = 0;
      cyc = 0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_state = s;
      tick();
      in_valid = 1'b0;
      while (idx < OW && cyc < 40) begin
         out_ready = ((cyc % 3) == 0);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_word(s, idx) ||
             out_last !== 1'(idx == OW - 1)) begin
            errors++;
            $display("FAIL bp_word%0d: got v=%b d=%h l=%b want 1 %h %b",
                     idx, out_valid, out_data, out_last,
                     exp_word(s, idx), 1'(idx == OW - 1));
         end
         if (out_ready) idx++;
         cyc++;
         tick();
      end
      checks++;
      if (idx != OW) begin
         errors++;
         $display("FAIL bp_count: got %0d beats want %0d", idx, OW);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_extra: got v=%b b=%b want 0 0", out_valid, busy);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [SW-1:0] s1;
      logic [SW-1:0] s2;
      s1 = rand_state();
      s2 = rand_state();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_state = s1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < OW; k++) begin
         if (k == OW - 1) begin
            in_valid = 1'b1;
            in_state = s2;
         end
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_word(s1, k)) begin
            errors++;
            $display("FAIL b2b_first%0d: got v=%b d=%h want 1 %h",
                     k, out_valid, out_data, exp_word(s1, k));
         end
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < OW; k++) begin
         if (k == 1) begin
            in_valid = 1'b1;
            in_state = rand_state();
         end else begin
            in_valid = 1'b0;
         end
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_word(s2, k) ||
             out_last !== 1'(k == OW - 1)) begin
            errors++;
            $display("FAIL b2b_second%0d: got v=%b d=%h l=%b want 1 %h %b",
                     k, out_valid, out_data, out_last,
                     exp_word(s2, k), 1'(k == OW - 1));
         end
         checks++;
         if (overrun !== 1'(k >= 2)) begin
            errors++;
            $display("FAIL b2b_overrun%0d: got %b want %b",
                     k, overrun, 1'(k >= 2));
         end
         tick();
      end
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL b2b_end: got v=%b b=%b o=%b want 0 0 1",
                  out_valid, busy, overrun);
      end
      tick();
   endtask

   task automatic test_enable();
      logic [SW-1:0] s;
      s = rand_state();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_state = s;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < OW; k++) begin
         if (k == 2) begin
            for (int g = 0; g < 5; g++) begin
               enable = 1'b0;
               in_valid = 1'($urandom_range(0, 1)) | 1'(g == 0);
               in_state = rand_state();
               #1;
               checks++;
               if (out_valid !== 1'b0 || busy !== 1'b1 ||
                   out_data !== exp_word(s, 2)) begin
                  errors++;
                  $display("FAIL en_gap%0d: got v=%b b=%b d=%h want 0 1 %h",
                           g, out_valid, busy, out_data, exp_word(s, 2));
               end
               tick();
            end
            enable = 1'b1;
            in_valid = 1'b0;
         end
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_word(s, k)) begin
            errors++;
            $display("FAIL en_word%0d: got v=%b d=%h want 1 %h",
                     k, out_valid, out_data, exp_word(s, k));
         end
         tick();
      end
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL en_end: got v=%b b=%b want 0 0", out_valid, busy);
      end
      tick();
   endtask

   task automatic test_bswap();
      logic [SW-1:0] s;
      logic [WW-1:0] want;
`ifdef KECCAK_OUT_BSWAP_EN
      want = 64'hEFCDAB8967452301;
`else
      want = 64'h0123456789ABCDEF;
`endif
      s = rand_state();
      s[WW-1:0] = 64'h0123456789ABCDEF;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_state = s;
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_data !== want) begin
         errors++;
         $display("FAIL bswap_lane0: got %h want %h", out_data, want);
      end
      for (int k = 0; k < OW; k++) tick();
   endtask

   task automatic test_reset_mid();
      logic [SW-1:0] s;
      s = rand_state();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_state = s;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_word(s, 2)) begin
         errors++;
         $display("FAIL rst_pre: got v=%b d=%h want 1 %h",
                  out_valid, out_data, exp_word(s, 2));
      end
      resetn = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_last, busy, overrun} !== 4'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL rst_mid: got v/l/b/o=%b d=%h want 0000 0",
                  {out_valid, out_last, busy, overrun}, out_data);
      end
      tick();
      resetn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after%0d: got v=%b b=%b want 0 0",
                     c, out_valid, busy);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_enable();
      test_bswap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
